mc_controller: RTL

Main control unit for the multicycle MIPS CPU. It sequences the shared datapath (PC, instruction/data memory port, IR, register file, ALU) through one state per cycle for each instruction, and drives every mux select and write enable. It contains the ALU decoder and stalls on a memory-ready handshake. It sits inside `cpu` beside the datapath and observes only `op`, `funct`, `zero` and `mem_ready`.

---
 rtl/mc_controller.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS main control FSM with ALU decoder and memory-ready stalls
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_IEXEC    = 4'd9,
    S_IWB      = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [2:0] funct_alu, imm_alu;
  logic       funct_ok, imm_zext;

  // ALU operation decode for R-type funct and I-type opcodes; IR is stable so IWB can re-decode op
  always_comb begin
    funct_ok = 1'b1;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default: begin
        funct_alu = 3'b010;
        funct_ok  = 1'b0;
      end
    endcase
    case (op)
      OP_ANDI: imm_alu = 3'b000;
      OP_ORI:  imm_alu = 3'b001;
      OP_SLTI: imm_alu = 3'b111;
      default: imm_alu = 3'b010;
    endcase
    imm_zext = (op == OP_ANDI) || (op == OP_ORI);
  end

  // Next-state selection; unsupported op or funct aborts to FETCH and raises the sticky flag
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                       state_d = S_MEMADR;
          OP_R:                               state_d = S_EXECUTE;
          OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_IEXEC;
          OP_J:                               state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE: begin
        state_d = funct_ok ? S_ALUWB : S_FETCH;
        if (!funct_ok) illegal_d = 1'b1;
      end
      S_IEXEC:    state_d = S_IWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // State and sticky illegal flag; asynchronous active-low reset returns to FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore decode from state; strobes gated by mem_ready/zero and forced low while reset is held
  always_comb begin
    pcen       = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroext    = 1'b0;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      S_DECODE:   alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMREAD:  iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen       = (op == OP_BNE) ? ~zero : zero;
      end
      S_IEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = imm_alu;
        zeroext    = imm_zext;
      end
      S_IWB: begin
        regwrite   = 1'b1;
        alucontrol = imm_alu;
        zeroext    = imm_zext;
      end
      S_JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    pcen     = pcen & reset;
    irwrite  = irwrite & reset;
    memwrite = memwrite & reset;
    regwrite = regwrite & reset;
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule
